// File: rtl/synth_pkg.sv
// Shared synthesiser definitions: operator count, accumulator sizing,
// phase output width and the control-side register map.
package synth_pkg;

  localparam int unsigned NUM_OPERATORS        = 32;
  localparam int unsigned ACCUMULATOR_WIDTH    = 24;
  localparam int unsigned PHASE_OUT_WIDTH      = 13;
  localparam int unsigned OPERATOR_INDEX_WIDTH = $clog2(NUM_OPERATORS);

  typedef logic [OPERATOR_INDEX_WIDTH-1:0] operator_index_t;
  typedef logic [ACCUMULATOR_WIDTH-1:0]    phase_step_t;

  // Register select on the write port; REG_RESERVED writes are dropped.
  typedef enum logic [1:0] {
    REG_PHASE_STEP = 2'd0,
    REG_WAVEFORM   = 2'd1,
    REG_KEY_ON     = 2'd2,
    REG_RESERVED   = 2'd3
  } register_select_t;

  typedef enum logic {
    STATE_IDLE  = 1'b0,
    STATE_SWEEP = 1'b1
  } sweep_state_t;

endpackage

// File: rtl/operator_ram.sv
// One-write, one-read synchronous RAM with a registered read port.
// A read and a write to the same address on the same edge returns the
// old contents. No reset so it maps onto block RAM.
module operator_ram #(
  parameter  int unsigned WIDTH      = 24,
  parameter  int unsigned DEPTH      = 32,
  localparam int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  i_Clock,
  input  logic                  i_WriteEnable,
  input  logic [ADDR_WIDTH-1:0] i_WriteAddress,
  input  logic [WIDTH-1:0]      i_WriteData,
  input  logic [ADDR_WIDTH-1:0] i_ReadAddress,
  output logic [WIDTH-1:0]      o_ReadData
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port and registered read port
  always_ff @(posedge i_Clock) begin
    if (i_WriteEnable) begin
      mem[i_WriteAddress] <= i_WriteData;
    end
    o_ReadData <= mem[i_ReadAddress];
  end

endmodule

// File: rtl/phase_generator.sv
// Time-multiplexed phase accumulator bank. Each sample tick sweeps every
// operator once: read (cycle k), add/write-back + output register (k+1),
// output visible (k+2).
module phase_generator #(
  parameter  int unsigned NUM_OPERATORS     = synth_pkg::NUM_OPERATORS,
  parameter  int unsigned ACCUMULATOR_WIDTH = synth_pkg::ACCUMULATOR_WIDTH,
  localparam int unsigned INDEX_WIDTH       = $clog2(NUM_OPERATORS)
) (
  input  logic                         i_Clock,
  input  logic                         i_Reset_n,
  input  logic                         i_SampleStart,
  input  logic                         i_WriteEnable,
  input  logic [INDEX_WIDTH-1:0]       i_WriteOperator,
  input  logic [1:0]                   i_WriteRegister,
  input  logic [ACCUMULATOR_WIDTH-1:0] i_WriteData,
  output logic [12:0]                  o_Phase,
  output logic                         o_Waveform,
  output logic [INDEX_WIDTH-1:0]       o_OperatorIndex,
  output logic                         o_Valid,
  output logic                         o_Busy,
  output logic                         o_SweepDone
);

  import synth_pkg::*;

  localparam logic [INDEX_WIDTH-1:0] LAST_OPERATOR = INDEX_WIDTH'(NUM_OPERATORS - 1);

  sweep_state_t           state;
  logic [INDEX_WIDTH-1:0] counter;
  logic                   start_accept;
  logic                   read_active;

  register_select_t       write_select;
  logic                   step_write;
  logic                   waveform_write;
  logic                   key_on_write;

  logic [NUM_OPERATORS-1:0] waveform_bits;
  logic [NUM_OPERATORS-1:0] key_on_flags;

  logic                   read_valid;
  logic [INDEX_WIDTH-1:0] read_index;
  logic                   read_key_on;
  logic                   read_waveform;

  logic [ACCUMULATOR_WIDTH-1:0] accumulator_rd;
  logic [ACCUMULATOR_WIDTH-1:0] step_rd;
  logic [ACCUMULATOR_WIDTH-1:0] used_accumulator;
  logic [ACCUMULATOR_WIDTH-1:0] next_accumulator;

  assign start_accept = i_SampleStart && !o_Busy;
  assign read_active  = (state == STATE_SWEEP);

  // Register port decode
  always_comb begin
    write_select   = register_select_t'(i_WriteRegister);
    step_write     = i_WriteEnable && (write_select == REG_PHASE_STEP);
    waveform_write = i_WriteEnable && (write_select == REG_WAVEFORM);
    key_on_write   = i_WriteEnable && (write_select == REG_KEY_ON);
  end

  // Sweep FSM, operator counter and busy flag (busy spans the pipeline tail)
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state   <= STATE_IDLE;
      counter <= '0;
      o_Busy  <= 1'b0;
    end else begin
      case (state)
        STATE_IDLE: begin
          if (start_accept) begin
            state   <= STATE_SWEEP;
            counter <= '0;
          end
        end
        STATE_SWEEP: begin
          counter <= counter + INDEX_WIDTH'(1);
          if (counter == LAST_OPERATOR) begin
            state <= STATE_IDLE;
          end
        end
        default: state <= STATE_IDLE;
      endcase

      if (o_SweepDone) begin
        o_Busy <= 1'b0;
      end else if (start_accept) begin
        o_Busy <= 1'b1;
      end
    end
  end

  // Waveform select flop array, written from the register port only
  always_ff @(posedge i_Clock) begin
    if (waveform_write) begin
      waveform_bits[i_WriteOperator] <= i_WriteData[0];
    end
  end

  // Key-on flags: set on reset or write, cleared when consumed by a read;
  // a write on the clearing edge keeps the flag set
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      key_on_flags <= '1;
    end else begin
      for (int unsigned i = 0; i < NUM_OPERATORS; i++) begin
        if (key_on_write && (i_WriteOperator == INDEX_WIDTH'(i))) begin
          key_on_flags[i] <= 1'b1;
        end else if (read_active && (counter == INDEX_WIDTH'(i))) begin
          key_on_flags[i] <= 1'b0;
        end
      end
    end
  end

  // Read stage: capture per-operator side info alongside the RAM reads
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      read_valid    <= 1'b0;
      read_index    <= '0;
      read_key_on   <= 1'b0;
      read_waveform <= 1'b0;
    end else begin
      read_valid    <= read_active;
      read_index    <= counter;
      read_key_on   <= key_on_flags[counter];
      read_waveform <= waveform_bits[counter];
    end
  end

  operator_ram #(
    .WIDTH (ACCUMULATOR_WIDTH),
    .DEPTH (NUM_OPERATORS)
  ) u_accumulator_ram (
    .i_Clock        (i_Clock),
    .i_WriteEnable  (read_valid),
    .i_WriteAddress (read_index),
    .i_WriteData    (next_accumulator),
    .i_ReadAddress  (counter),
    .o_ReadData     (accumulator_rd)
  );

  operator_ram #(
    .WIDTH (ACCUMULATOR_WIDTH),
    .DEPTH (NUM_OPERATORS)
  ) u_step_ram (
    .i_Clock        (i_Clock),
    .i_WriteEnable  (step_write),
    .i_WriteAddress (i_WriteOperator),
    .i_WriteData    (i_WriteData),
    .i_ReadAddress  (counter),
    .o_ReadData     (step_rd)
  );

  // Key-on restarts the operator from zero; accumulator wraps unsigned
  always_comb begin
    used_accumulator = read_key_on ? '0 : accumulator_rd;
    next_accumulator = used_accumulator + step_rd;
  end

  // Output registers; data holds its last value when not valid
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      o_Phase         <= '0;
      o_Waveform      <= 1'b0;
      o_OperatorIndex <= '0;
      o_Valid         <= 1'b0;
      o_SweepDone     <= 1'b0;
    end else begin
      o_Valid     <= read_valid;
      o_SweepDone <= read_valid && (read_index == LAST_OPERATOR);
      if (read_valid) begin
        o_Phase         <= used_accumulator[ACCUMULATOR_WIDTH-1 -: PHASE_OUT_WIDTH];
        o_Waveform      <= read_waveform;
        o_OperatorIndex <= read_index;
      end
    end
  end

endmodule

// File: tb/tb_phase_generator.sv
// Directed bench for phase_generator with hand-computed expectations.
module tb_phase_generator;

  localparam int N = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        we;
  logic [4:0]  wop;
  logic [1:0]  wreg;
  logic [23:0] wdata;
  logic [12:0] o_Phase;
  logic        o_Waveform;
  logic [4:0]  o_OperatorIndex;
  logic        o_Valid;
  logic        o_Busy;
  logic        o_SweepDone;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [12:0] cap_phase [N];
  logic        cap_wave  [N];
  int nvalid, valid_first, valid_last, done_count, done_cycle;
  int busy_first, busy_last, order_err;

  localparam logic [1:0] SEL_STEP  = 2'd0;
  localparam logic [1:0] SEL_WAVE  = 2'd1;
  localparam logic [1:0] SEL_KEYON = 2'd2;

  phase_generator #(
    .NUM_OPERATORS     (32),
    .ACCUMULATOR_WIDTH (24)
  ) dut (
    .i_Clock         (clk),
    .i_Reset_n       (rst_n),
    .i_SampleStart   (start),
    .i_WriteEnable   (we),
    .i_WriteOperator (wop),
    .i_WriteRegister (wreg),
    .i_WriteData     (wdata),
    .o_Phase         (o_Phase),
    .o_Waveform      (o_Waveform),
    .o_OperatorIndex (o_OperatorIndex),
    .o_Valid         (o_Valid),
    .o_Busy          (o_Busy),
    .o_SweepDone     (o_SweepDone)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic write_reg(input int op, input logic [1:0] sel, input logic [23:0] data);
    @(posedge clk); #1;
    we = 1'b1; wop = op[4:0]; wreg = sel; wdata = data;
    @(posedge clk); #1;
    we = 1'b0;
  endtask

  // Start a sweep at edge t and record 40 cycles of outputs. Optionally a
  // second start in cycle t+start2 and a register write in cycle t+wr_cycle.
  task automatic run_sweep(input int start2, input int wr_cycle, input int wr_op,
                           input logic [1:0] wr_sel, input logic [23:0] wr_data);
    nvalid = 0; valid_first = -1; valid_last = -1; done_count = 0; done_cycle = -1;
    busy_first = -1; busy_last = -1; order_err = 0;
    for (int i = 0; i < N; i++) begin
      cap_phase[i] = 13'h1FFF;
      cap_wave[i]  = 1'b1;
    end
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      start = (c == start2);
      we    = (c == wr_cycle);
      if (c == wr_cycle) begin
        wop = wr_op[4:0]; wreg = wr_sel; wdata = wr_data;
      end
      @(negedge clk);
      if (o_Valid) begin
        if (o_OperatorIndex != nvalid[4:0]) order_err++;
        cap_phase[o_OperatorIndex] = o_Phase;
        cap_wave[o_OperatorIndex]  = o_Waveform;
        if (valid_first < 0) valid_first = c;
        valid_last = c;
        nvalid++;
      end
      if (o_SweepDone) begin
        done_count++;
        done_cycle = c;
      end
      if (o_Busy) begin
        if (busy_first < 0) busy_first = c;
        busy_last = c;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    we    = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests_run++; if (o_Phase !== 13'h0) begin tests_failed++; $display("FAIL reset_phase: got %h want 0", o_Phase); end
    tests_run++; if (o_Waveform !== 1'b0) begin tests_failed++; $display("FAIL reset_waveform: got %b want 0", o_Waveform); end
    tests_run++; if (o_OperatorIndex !== 5'd0) begin tests_failed++; $display("FAIL reset_index: got %0d want 0", o_OperatorIndex); end
    tests_run++; if (o_Valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b want 0", o_Valid); end
    tests_run++; if (o_Busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", o_Busy); end
    tests_run++; if (o_SweepDone !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b want 0", o_SweepDone); end
  endtask

  task automatic test_basic_sweep();
    logic [12:0] exp0 [3];
    logic [12:0] exp1 [3];
    exp0[0] = 13'h0000; exp0[1] = 13'h0002; exp0[2] = 13'h0004;
    exp1[0] = 13'h0000; exp1[1] = 13'h1000; exp1[2] = 13'h0000;
    write_reg(0, SEL_STEP, 24'h001000);
    write_reg(1, SEL_STEP, 24'h800000);
    for (int s = 0; s < 3; s++) begin
      run_sweep(0, 0, 0, SEL_STEP, 24'h0);
      tests_run++; if (cap_phase[0] !== exp0[s]) begin tests_failed++; $display("FAIL basic_op0_sweep%0d: got %h want %h", s, cap_phase[0], exp0[s]); end
      tests_run++; if (cap_phase[1] !== exp1[s]) begin tests_failed++; $display("FAIL basic_op1_sweep%0d: got %h want %h", s, cap_phase[1], exp1[s]); end
      tests_run++; if (nvalid !== 32) begin tests_failed++; $display("FAIL basic_count_sweep%0d: got %0d want 32", s, nvalid); end
    end
  endtask

  task automatic test_latency_framing();
    run_sweep(0, 0, 0, SEL_STEP, 24'h0);
    tests_run++; if (valid_first !== 3) begin tests_failed++; $display("FAIL valid_first: got %0d want 3", valid_first); end
    tests_run++; if (valid_last !== 34) begin tests_failed++; $display("FAIL valid_last: got %0d want 34", valid_last); end
    tests_run++; if (nvalid !== 32) begin tests_failed++; $display("FAIL valid_count: got %0d want 32", nvalid); end
    tests_run++; if (order_err !== 0) begin tests_failed++; $display("FAIL index_order: got %0d errors want 0", order_err); end
    tests_run++; if (done_count !== 1) begin tests_failed++; $display("FAIL done_count: got %0d want 1", done_count); end
    tests_run++; if (done_cycle !== 34) begin tests_failed++; $display("FAIL done_cycle: got %0d want 34", done_cycle); end
    tests_run++; if (busy_first !== 1) begin tests_failed++; $display("FAIL busy_first: got %0d want 1", busy_first); end
    tests_run++; if (busy_last !== 34) begin tests_failed++; $display("FAIL busy_last: got %0d want 34", busy_last); end
  endtask

  task automatic test_ignored_start();
    run_sweep(10, 0, 0, SEL_STEP, 24'h0);
    tests_run++; if (nvalid !== 32) begin tests_failed++; $display("FAIL ignored_start_count: got %0d want 32", nvalid); end
    tests_run++; if (valid_last !== 34) begin tests_failed++; $display("FAIL ignored_start_last: got %0d want 34", valid_last); end
    tests_run++; if (o_Busy !== 1'b0) begin tests_failed++; $display("FAIL ignored_start_busy: got %b want 0", o_Busy); end
  endtask

  task automatic test_key_on();
    logic [12:0] exp_run [4];
    exp_run[0] = 13'h000; exp_run[1] = 13'h200; exp_run[2] = 13'h400; exp_run[3] = 13'h600;
    write_reg(5, SEL_STEP, 24'h100000);
    for (int s = 0; s < 4; s++) begin
      run_sweep(0, 0, 0, SEL_STEP, 24'h0);
      tests_run++; if (cap_phase[5] !== exp_run[s]) begin tests_failed++; $display("FAIL keyon_run%0d: got %h want %h", s, cap_phase[5], exp_run[s]); end
    end
    write_reg(5, SEL_KEYON, 24'h0);
    run_sweep(0, 0, 0, SEL_STEP, 24'h0);
    tests_run++; if (cap_phase[5] !== 13'h000) begin tests_failed++; $display("FAIL keyon_restart: got %h want 000", cap_phase[5]); end
    run_sweep(0, 0, 0, SEL_STEP, 24'h0);
    tests_run++; if (cap_phase[5] !== 13'h200) begin tests_failed++; $display("FAIL keyon_after: got %h want 200", cap_phase[5]); end
    // key-on write lands on op 5's read cycle (t+6)
    run_sweep(0, 6, 5, SEL_KEYON, 24'h0);
    tests_run++; if (cap_phase[5] !== 13'h400) begin tests_failed++; $display("FAIL keyon_coincide_pass: got %h want 400", cap_phase[5]); end
    run_sweep(0, 0, 0, SEL_STEP, 24'h0);
    tests_run++; if (cap_phase[5] !== 13'h000) begin tests_failed++; $display("FAIL keyon_coincide_next: got %h want 000", cap_phase[5]); end
  endtask

  task automatic test_mid_sweep_write();
    write_reg(7, SEL_STEP, 24'h010000);
    run_sweep(0, 0, 0, SEL_STEP, 24'h0);
    tests_run++; if (cap_phase[7] !== 13'h000) begin tests_failed++; $display("FAIL midwr_a: got %h want 000", cap_phase[7]); end
    // op 7 is read in cycle t+8
    run_sweep(0, 8, 7, SEL_STEP, 24'h020000);
    tests_run++; if (cap_phase[7] !== 13'h020) begin tests_failed++; $display("FAIL midwr_b: got %h want 020", cap_phase[7]); end
    run_sweep(0, 0, 0, SEL_STEP, 24'h0);
    tests_run++; if (cap_phase[7] !== 13'h040) begin tests_failed++; $display("FAIL midwr_old_step: got %h want 040", cap_phase[7]); end
    run_sweep(0, 0, 0, SEL_STEP, 24'h0);
    tests_run++; if (cap_phase[7] !== 13'h080) begin tests_failed++; $display("FAIL midwr_new_step: got %h want 080", cap_phase[7]); end
    run_sweep(0, 8, 7, SEL_WAVE, 24'h000001);
    tests_run++; if (cap_wave[7] !== 1'b0) begin tests_failed++; $display("FAIL midwr_wave_same: got %b want 0", cap_wave[7]); end
    run_sweep(0, 0, 0, SEL_STEP, 24'h0);
    tests_run++; if (cap_wave[7] !== 1'b1) begin tests_failed++; $display("FAIL midwr_wave_next: got %b want 1", cap_wave[7]); end
    tests_run++; if (cap_wave[6] !== 1'b0) begin tests_failed++; $display("FAIL midwr_wave_neighbour: got %b want 0", cap_wave[6]); end
  endtask

  task automatic test_reset_mid_sweep();
    int nonzero;
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (11) @(posedge clk);
    #3;
    tests_run++; if (o_Valid !== 1'b1) begin tests_failed++; $display("FAIL midrst_pre_valid: got %b want 1", o_Valid); end
    rst_n = 1'b0;
    #1;
    tests_run++; if (o_Phase !== 13'h0) begin tests_failed++; $display("FAIL midrst_phase: got %h want 0", o_Phase); end
    tests_run++; if (o_OperatorIndex !== 5'd0) begin tests_failed++; $display("FAIL midrst_index: got %0d want 0", o_OperatorIndex); end
    tests_run++; if (o_Valid !== 1'b0) begin tests_failed++; $display("FAIL midrst_valid: got %b want 0", o_Valid); end
    tests_run++; if (o_Busy !== 1'b0) begin tests_failed++; $display("FAIL midrst_busy: got %b want 0", o_Busy); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_sweep(0, 0, 0, SEL_STEP, 24'h0);
    nonzero = 0;
    for (int i = 0; i < N; i++) if (cap_phase[i] !== 13'h0) nonzero++;
    tests_run++; if (nonzero !== 0) begin tests_failed++; $display("FAIL midrst_phases: got %0d nonzero want 0", nonzero); end
    tests_run++; if (nvalid !== 32) begin tests_failed++; $display("FAIL midrst_count: got %0d want 32", nvalid); end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; we = 1'b0; wop = '0; wreg = '0; wdata = '0;
    repeat (3) @(posedge clk);
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) begin
      write_reg(i, SEL_STEP, 24'h0);
      write_reg(i, SEL_WAVE, 24'h0);
    end
    test_basic_sweep();
    test_latency_framing();
    test_ignored_start();
    test_key_on();
    test_mid_sweep_write();
    test_reset_mid_sweep();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
